prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
- REQ-001: Parameter AUTO_RUN, default 1: when 1, the CPU is released after a good checksum; when 0, it waits for run_req.
- REQ-002: Parameter CKSUM_EN, default 1: when 1, a 17th checksum byte is expected after the 16 program bytes; when 0, there is no checksum byte.
- REQ-003: clock  input  1  single system clock; all state updates on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: load_start  input  1  one-cycle request to begin a program download.
- REQ-006: in_valid  input  1  the byte on in_data is valid.
- REQ-007: in_data  input  data_t (8)  download byte.
- REQ-008: in_ready  output  1  the loader accepts in_data this cycle.
- REQ-009: run_req  input  1  manual CPU release; used only when AUTO_RUN=0.
- REQ-010: addr  input  addr_t (4)  CPU fetch address.
- REQ-011: data  output  data_t (8)  instruction returned to the CPU.
- REQ-012: cpu_reset  output  1  holds the CPU in reset while asserted.
- REQ-013: done  output  1  a program is loaded and the CPU is running.
- REQ-014: error  output  1  the checksum did not match; sticky until the next load_start or reset.

Function
- REQ-015: States SHALL be IDLE, LOAD, CHECK, WAIT, RUN, ERR; the state after reset SHALL be IDLE.
- REQ-016: Internal storage SHALL be a 16 x 8 register array.
- REQ-017: Internal counters: wptr (5 bits), 8-bit running sum.
- REQ-018: IDLE:
  - cpu_reset=1, in_ready=0;
  - load_start -> LOAD next cycle, with wptr=0, sum=0, error=0.
- REQ-019: LOAD:
  - in_ready=1.
  - A transfer occurs only on a cycle where in_valid and in_ready are both 1.
  - Each transfer writes mem[wptr[3:0]]=in_data, increments wptr, and sets sum=sum+in_data mod 256.
- REQ-020: On the 16th transfer (wptr==15):
  - go to CHECK if CKSUM_EN=1;
  - otherwise go to RUN if AUTO_RUN=1, else WAIT.
- REQ-021: CHECK:
  - in_ready=1; the next transfer is the checksum byte and is not stored.
  - If in_data == (~sum + 1) mod 256 (two's complement, i.e. all 17 bytes sum to 0): go to RUN if AUTO_RUN=1, else WAIT.
  - Otherwise go to ERR.
- REQ-022: WAIT: cpu_reset=1, in_ready=0; run_req -> RUN.
- REQ-023: RUN:
  - cpu_reset=0, done=1, in_ready=0.
  - The first cycle with cpu_reset=0 is the cycle after the transition edge.
- REQ-024: ERR: cpu_reset=1, error=1, in_ready=0, done=0.
- REQ-025: load_start is honoured in every state.
  - In any state it restarts at LOAD on the next cycle with wptr=0, sum=0, done=0, error=0, cpu_reset=1.
  - In LOAD or CHECK this applies even mid-download.
  - A byte transfer in the same cycle as load_start is discarded.
- REQ-026: In RUN, data = mem[addr] combinationally (zero-latency read); in all other states data = 8'h00.
- REQ-027: Memory writes occur only in LOAD; a partial reload leaves the unwritten locations holding their prior contents.
- REQ-028: in_valid outside LOAD/CHECK is ignored, with no side effects.
- REQ-029: cpu_reset, done and error are registered outputs.
- REQ-030: in_ready is decoded from the current state.

Reset
- REQ-031: On reset, the following SHALL take effect at the next rising edge: state=IDLE, wptr=0, sum=0, all 16 memory words=8'h00, cpu_reset=1, done=0, error=0.
- REQ-032: Reset SHALL override load_start, in_valid and run_req in the same cycle.
- REQ-033: A reset asserted during LOAD, CHECK or RUN SHALL abort the download and return the loader to IDLE.

Verification
- REQ-034: Good load, AUTO_RUN=1, CKSUM_EN=1:
  - stimulus: load_start, then bytes 8'h01..8'h10 (sum 8'h88), then checksum 8'h78;
  - response: RUN, cpu_reset=0, done=1; addr=4'h0 reads 8'h01 and addr=4'hF reads 8'h10.
- REQ-035: Bad checksum:
  - stimulus: the same 16 bytes, then checksum 8'h79;
  - response: ERR, error=1, cpu_reset=1, data=8'h00 for every addr.
- REQ-036: Back-pressure / gaps:
  - stimulus: in_valid toggled 1,0,0,1 across 16 bytes;
  - response: exactly 16 writes, in order, with no duplicates.
- REQ-037: Abort:
  - stimulus: load_start again after 5 bytes, then 16 fresh bytes plus checksum;
  - response: mem[0..15] holds the fresh bytes and done=1.
- REQ-038: AUTO_RUN=0, CKSUM_EN=0:
  - stimulus: 16 bytes loaded;
  - response: WAIT, cpu_reset=1; run_req pulse -> cpu_reset=0 on the next cycle.
- REQ-039: Reset mid-load:
  - stimulus: reset asserted after 8 bytes;
  - response: IDLE, all memory words 8'h00, in_ready=0, done=0, error=0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: streams 16 instruction bytes (plus optional checksum) into a
// small register file, then releases the CPU and serves fetches from it.
package prog_loader_pkg;
  typedef logic [7:0] data_t;
  typedef logic [3:0] addr_t;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, WAIT, RUN, ERR} state_t;
endpackage

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter bit AUTO_RUN = 1'b1,
  parameter bit CKSUM_EN = 1'b1
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load_start,
  input  logic  in_valid,
  input  data_t in_data,
  output logic  in_ready,
  input  logic  run_req,
  input  addr_t addr,
  output data_t data,
  output logic  cpu_reset,
  output logic  done,
  output logic  error
);

  state_t      state_q, state_d;
  logic [4:0]  wptr_q, wptr_d;
  data_t       sum_q, sum_d;
  data_t       mem_q [16];
  data_t       mem_d [16];
  logic        cpu_reset_q, done_q, error_q;
  logic        xfer;
  state_t      after_load;

  assign in_ready   = (state_q == LOAD) || (state_q == CHECK);
  assign xfer       = in_valid && in_ready;
  assign after_load = AUTO_RUN ? RUN : WAIT;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    mem_d   = mem_q;
    // A restart wins over everything, including a byte offered the same cycle.
    if (load_start) begin
      state_d = LOAD;
      wptr_d  = 5'd0;
      sum_d   = 8'h00;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            mem_d[wptr_q[3:0]] = in_data;
            wptr_d             = wptr_q + 5'd1;
            sum_d              = sum_q + in_data;
            if (wptr_q == 5'd15) begin
              state_d = CKSUM_EN ? CHECK : after_load;
            end else begin
              state_d = LOAD;
            end
          end else begin
            state_d = LOAD;
          end
        end
        CHECK: begin
          if (xfer) begin
            state_d = (in_data == data_t'(~sum_q + 8'd1)) ? after_load : ERR;
          end else begin
            state_d = CHECK;
          end
        end
        WAIT: begin
          if (run_req) begin
            state_d = RUN;
          end else begin
            state_d = WAIT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    if (state_q == RUN) begin
      data = mem_q[addr];
    end else begin
      data = 8'h00;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= 5'd0;
      sum_q       <= 8'h00;
      mem_q       <= '{default: 8'h00};
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      sum_q       <= sum_d;
      mem_q       <= mem_d;
      cpu_reset_q <= (state_d != RUN);
      done_q      <= (state_d == RUN);
      error_q     <= (state_d == ERR);
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
